// File: rtl/except_ctrl_pkg.sv
// Shared constants and types for the exception/stall sequencer.
// Exception codes, CP0 register addresses, stall encodings and FSM states.
package except_ctrl_pkg;

   localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
   localparam logic [31:0] EXC_INT     = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] EXC_RI      = 32'h0000_000a;
   localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
   localparam logic [31:0] EXC_OV      = 32'h0000_000c;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   // Bit positions inside the MEM-stage flag vector {eret, ov, trap, ri, syscall}
   localparam int unsigned FLAG_SYSCALL = 0;
   localparam int unsigned FLAG_RI      = 1;
   localparam int unsigned FLAG_TRAP    = 2;
   localparam int unsigned FLAG_OV      = 3;
   localparam int unsigned FLAG_ERET    = 4;

   // Stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;

   typedef enum logic [0:0] {
      StIdle,
      StFlush
   } state_e;

   // Software-writable Cause fields: IP1..IP0 [9:8], IV [23], WP [22]
   function automatic logic [31:0] cause_fwd(input logic [31:0] cause, input logic [31:0] data);
      logic [31:0] res;
      res        = cause;
      res[9:8]   = data[9:8];
      res[23:22] = data[23:22];
      return res;
   endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Combinational exception decision: CP0 forwarding from WB, pending-interrupt
// check and fixed-priority encoding of the MEM-stage exception flags.
// With IRQ_SYNC_EN defined, synchronized external interrupts join Cause[15:10].
module exc_priority_enc
   import except_ctrl_pkg::*;
(
   input  logic        decide,
   input  logic [4:0]  mem_exc_flags,
   input  logic [31:0] cp0_status,
   input  logic [31:0] cp0_cause,
   input  logic [31:0] cp0_epc,
   input  logic        wb_cp0_we,
   input  logic [4:0]  wb_cp0_waddr,
   input  logic [31:0] wb_cp0_data,
`ifdef IRQ_SYNC_EN
   input  logic [5:0]  int_sync,
`endif
   output logic [31:0] code,
   output logic [31:0] epc_eff
);

   logic [31:0] status_eff;
   logic [31:0] cause_eff;
   logic        int_pending;
   logic        unused_bits;

   // Effective CP0 values with in-flight WB writes forwarded
   always_comb begin
      status_eff = cp0_status;
      cause_eff  = cp0_cause;
      epc_eff    = cp0_epc;
      if (wb_cp0_we && (wb_cp0_waddr == CP0_STATUS)) status_eff = wb_cp0_data;
      if (wb_cp0_we && (wb_cp0_waddr == CP0_CAUSE))  cause_eff  = cause_fwd(cp0_cause, wb_cp0_data);
      if (wb_cp0_we && (wb_cp0_waddr == CP0_EPC))    epc_eff    = wb_cp0_data;
`ifdef IRQ_SYNC_EN
      cause_eff[15:10] = cause_eff[15:10] | int_sync;
`endif
   end

   assign int_pending = status_eff[0] & ~status_eff[1] & (|(cause_eff[15:8] & status_eff[15:8]));

   // Only IE/EXL/IM of Status and IP of Cause matter here
   assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

   // Fixed priority: interrupt > syscall > ri > trap > ov > eret
   always_comb begin
      code = EXC_NONE;
      if (decide) begin
         if (int_pending)                     code = EXC_INT;
         else if (mem_exc_flags[FLAG_SYSCALL]) code = EXC_SYSCALL;
         else if (mem_exc_flags[FLAG_RI])      code = EXC_RI;
         else if (mem_exc_flags[FLAG_TRAP])    code = EXC_TRAP;
         else if (mem_exc_flags[FLAG_OV])      code = EXC_OV;
         else if (mem_exc_flags[FLAG_ERET])    code = EXC_ERET;
      end
   end

endmodule

// File: rtl/except_ctrl.sv
// Pipeline exception and stall sequencer: takes the exception decision, runs a
// FLUSH_CYCLES-long flush with redirect PC, and arbitrates the stall vector.
// Optional feature macro IRQ_SYNC_EN adds int_i with a 2-flop synchronizer.
module except_ctrl
   import except_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned STALL_W      = 6
) (
   input  logic               clk,
   input  logic               rst,
`ifdef IRQ_SYNC_EN
   input  logic [5:0]         int_i,
`endif
   input  logic               stallreq_id_i,
   input  logic               stallreq_ex_i,
   input  logic               mem_valid_i,
   input  logic [4:0]         mem_exc_flags_i,
   input  logic [31:0]        mem_pc_i,
   input  logic               mem_in_delayslot_i,
   input  logic [31:0]        cp0_status_i,
   input  logic [31:0]        cp0_cause_i,
   input  logic [31:0]        cp0_epc_i,
   input  logic               wb_cp0_we_i,
   input  logic [4:0]         wb_cp0_waddr_i,
   input  logic [31:0]        wb_cp0_data_i,
   output logic [31:0]        excepttype_o,
   output logic [31:0]        exc_pc_o,
   output logic               exc_in_delayslot_o,
   output logic               flush_o,
   output logic [31:0]        new_pc_o,
   output logic [STALL_W-1:0] stall_o,
   output logic               busy_o
);

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic        decide;
   logic        take;
   logic [31:0] code;
   logic [31:0] epc_eff;
   logic [31:0] target;

`ifdef IRQ_SYNC_EN
   logic [5:0] int_meta_q;
   logic [5:0] int_sync_q;

   // Two-flop synchronizer for asynchronous interrupt lines
   always_ff @(posedge clk) begin
      if (rst) begin
         int_meta_q <= '0;
         int_sync_q <= '0;
      end else begin
         int_meta_q <= int_i;
         int_sync_q <= int_meta_q;
      end
   end
`endif

   assign decide = ~rst & mem_valid_i & (state_q == StIdle);

   exc_priority_enc u_prio (
      .decide        (decide),
      .mem_exc_flags (mem_exc_flags_i),
      .cp0_status    (cp0_status_i),
      .cp0_cause     (cp0_cause_i),
      .cp0_epc       (cp0_epc_i),
      .wb_cp0_we     (wb_cp0_we_i),
      .wb_cp0_waddr  (wb_cp0_waddr_i),
      .wb_cp0_data   (wb_cp0_data_i),
`ifdef IRQ_SYNC_EN
      .int_sync      (int_sync_q),
`endif
      .code          (code),
      .epc_eff       (epc_eff)
   );

   assign take   = (code != EXC_NONE);
   assign target = (code == EXC_ERET) ? epc_eff : EXC_VECTOR;

   // Next-state logic: the decision cycle is itself the first flush cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      new_pc_d = new_pc_q;
      case (state_q)
         StIdle: begin
            if (take) begin
               new_pc_d = target;
               cnt_d    = CNT_LOAD;
               if (FLUSH_CYCLES > 1) state_d = StFlush;
            end
         end
         StFlush: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, flush counter and redirect PC registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         new_pc_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         new_pc_q <= new_pc_d;
      end
   end

   // Outputs to CP0 and pipeline; flush dominates any stall request
   always_comb begin
      excepttype_o       = code;
      exc_pc_o           = take ? mem_pc_i : 32'd0;
      exc_in_delayslot_o = take & mem_in_delayslot_i;
      flush_o            = ~rst & (take | (state_q == StFlush));
      busy_o             = ~rst & (state_q == StFlush);
      new_pc_o           = take ? target : new_pc_q;
      stall_o            = STALL_W'(STALL_NONE);
      if (!rst && !flush_o) begin
         if (stallreq_ex_i)      stall_o = STALL_W'(STALL_EX);
         else if (stallreq_id_i) stall_o = STALL_W'(STALL_ID);
      end
   end

endmodule

// File: tb/tb_except_ctrl.sv
// Scoreboard bench for except_ctrl: the driver pushes one expected output
// record per cycle; a negedge monitor pops and compares it.
module tb_except_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id_i, stallreq_ex_i, mem_valid_i, mem_in_delayslot_i;
   logic [4:0]  mem_exc_flags_i;
   logic [31:0] mem_pc_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic [31:0] excepttype_o, exc_pc_o, new_pc_o;
   logic        exc_in_delayslot_o, flush_o, busy_o;
   logic [5:0]  stall_o;
`ifdef IRQ_SYNC_EN
   logic [5:0]  int_i = 6'd0;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      bit          chk;
      logic [31:0] code;
      logic [31:0] pc;
      logic        ds;
      logic        fl;
      logic        bz;
      logic [5:0]  st;
      logic [31:0] npc;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   except_ctrl dut (
      .clk                (clk),
      .rst                (rst),
`ifdef IRQ_SYNC_EN
      .int_i              (int_i),
`endif
      .stallreq_id_i      (stallreq_id_i),
      .stallreq_ex_i      (stallreq_ex_i),
      .mem_valid_i        (mem_valid_i),
      .mem_exc_flags_i    (mem_exc_flags_i),
      .mem_pc_i           (mem_pc_i),
      .mem_in_delayslot_i (mem_in_delayslot_i),
      .cp0_status_i       (cp0_status_i),
      .cp0_cause_i        (cp0_cause_i),
      .cp0_epc_i          (cp0_epc_i),
      .wb_cp0_we_i        (wb_cp0_we_i),
      .wb_cp0_waddr_i     (wb_cp0_waddr_i),
      .wb_cp0_data_i      (wb_cp0_data_i),
      .excepttype_o       (excepttype_o),
      .exc_pc_o           (exc_pc_o),
      .exc_in_delayslot_o (exc_in_delayslot_o),
      .flush_o            (flush_o),
      .new_pc_o           (new_pc_o),
      .stall_o            (stall_o),
      .busy_o             (busy_o)
   );

   task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s %s: got 0x%0h expected 0x%0h", nm, fld, got, want);
      end
   endtask

   // Monitor: one record per cycle, sampled mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.chk) begin
            cmp(e.name, "excepttype", excepttype_o, e.code);
            cmp(e.name, "exc_pc", exc_pc_o, e.pc);
            cmp(e.name, "delayslot", {31'd0, exc_in_delayslot_o}, {31'd0, e.ds});
            cmp(e.name, "flush", {31'd0, flush_o}, {31'd0, e.fl});
            cmp(e.name, "busy", {31'd0, busy_o}, {31'd0, e.bz});
            cmp(e.name, "stall", {26'd0, stall_o}, {26'd0, e.st});
            cmp(e.name, "new_pc", new_pc_o, e.npc);
         end
      end
   end

   task automatic clr();
      stallreq_id_i      = 1'b0;
      stallreq_ex_i      = 1'b0;
      mem_valid_i        = 1'b0;
      mem_exc_flags_i    = 5'd0;
      mem_pc_i           = 32'd0;
      mem_in_delayslot_i = 1'b0;
      cp0_status_i       = 32'd0;
      cp0_cause_i        = 32'd0;
      cp0_epc_i          = 32'd0;
      wb_cp0_we_i        = 1'b0;
      wb_cp0_waddr_i     = 5'd0;
      wb_cp0_data_i      = 32'd0;
   endtask

   task automatic push_rec(input string nm, input bit chk, input logic [31:0] code,
                           input logic [31:0] pc, input logic ds, input logic fl,
                           input logic bz, input logic [5:0] st, input logic [31:0] npc);
      exp_t e;
      e.name = nm; e.chk = chk; e.code = code; e.pc = pc; e.ds = ds;
      e.fl = fl; e.bz = bz; e.st = st; e.npc = npc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string nm, input logic [31:0] code, input logic [31:0] pc,
                       input logic ds, input logic fl, input logic bz, input logic [5:0] st,
                       input logic [31:0] npc);
      push_rec(nm, 1'b1, code, pc, ds, fl, bz, st, npc);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clr();
      @(posedge clk);
      #1;
      step("reset0", 0, 0, 0, 0, 0, 6'b0, 0);
      step("reset1", 0, 0, 0, 0, 0, 6'b0, 0);
      rst = 1'b0;
      step("idle", 0, 0, 0, 0, 0, 6'b0, 0);

      // Syscall: code for one cycle, two flush cycles, vector redirect
      mem_valid_i = 1; mem_exc_flags_i = 5'b00001; mem_pc_i = 32'h100;
      cp0_status_i = 32'h1000_0000;
      step("sys_dec", 32'h8, 32'h100, 0, 1, 0, 6'b0, 32'h20);
      clr();
      step("sys_fl", 0, 0, 0, 1, 1, 6'b0, 32'h20);
      step("sys_end", 0, 0, 0, 0, 0, 6'b0, 32'h20);

      // ERET with EPC forwarded from WB
      mem_valid_i = 1; mem_exc_flags_i = 5'b10000; mem_pc_i = 32'h200; cp0_epc_i = 32'h300;
      wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h400;
      step("eret_fwd", 32'he, 32'h200, 0, 1, 0, 6'b0, 32'h400);
      clr();
      step("eret_fl", 0, 0, 0, 1, 1, 6'b0, 32'h400);
      step("eret_end", 0, 0, 0, 0, 0, 6'b0, 32'h400);

      // Interrupt beats ov; delay-slot flag passes through
      mem_valid_i = 1; mem_exc_flags_i = 5'b01000; mem_pc_i = 32'h500; mem_in_delayslot_i = 1;
      cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
      step("int_dec", 32'h1, 32'h500, 1, 1, 0, 6'b0, 32'h20);
      clr();
      step("int_fl", 0, 0, 0, 1, 1, 6'b0, 32'h20);

      // Masked interrupt cases
      mem_valid_i = 1; mem_pc_i = 32'h600; cp0_status_i = 32'h0000_0403;
      cp0_cause_i = 32'h0000_0400;
      step("int_exl", 0, 0, 0, 0, 0, 6'b0, 32'h20);
      mem_valid_i = 0; cp0_status_i = 32'h0000_0401;
      step("int_bubble", 0, 0, 0, 0, 0, 6'b0, 32'h20);
      mem_valid_i = 1; wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000_0400;
      step("int_ie_fwd", 0, 0, 0, 0, 0, 6'b0, 32'h20);
      // Cause forwarding only touches bits 9:8, 22, 23
      cp0_cause_i = 32'h0; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h0000_0400;
      step("cause_ro", 0, 0, 0, 0, 0, 6'b0, 32'h20);
      cp0_status_i = 32'h0000_0101; wb_cp0_data_i = 32'h0000_0100; mem_pc_i = 32'h700;
      step("cause_fwd", 32'h1, 32'h700, 0, 1, 0, 6'b0, 32'h20);
      clr();
      step("cause_fl", 0, 0, 0, 1, 1, 6'b0, 32'h20);

      // Stall arbitration, then flush overriding stall
      stallreq_ex_i = 1;
      step("stall_ex", 0, 0, 0, 0, 0, 6'b001111, 32'h20);
      stallreq_ex_i = 0; stallreq_id_i = 1;
      step("stall_id", 0, 0, 0, 0, 0, 6'b000111, 32'h20);
      stallreq_ex_i = 1;
      step("stall_both", 0, 0, 0, 0, 0, 6'b001111, 32'h20);
      stallreq_id_i = 0;
      mem_valid_i = 1; mem_exc_flags_i = 5'b00010; mem_pc_i = 32'h800;
      step("ri_stall", 32'ha, 32'h800, 0, 1, 0, 6'b0, 32'h20);
      mem_valid_i = 0; mem_exc_flags_i = 0; mem_pc_i = 0;
      step("ri_fl", 0, 0, 0, 1, 1, 6'b0, 32'h20);
      step("ri_end", 0, 0, 0, 0, 0, 6'b001111, 32'h20);
      clr();

      // Priority among flags
      mem_valid_i = 1; mem_pc_i = 32'h840; mem_exc_flags_i = 5'b11111;
      step("prio_sys", 32'h8, 32'h840, 0, 1, 0, 6'b0, 32'h20);
      mem_valid_i = 0;
      step("prio_fl1", 0, 0, 0, 1, 1, 6'b0, 32'h20);
      mem_valid_i = 1; mem_exc_flags_i = 5'b11110;
      step("prio_ri", 32'ha, 32'h840, 0, 1, 0, 6'b0, 32'h20);
      mem_valid_i = 0;
      step("prio_fl2", 0, 0, 0, 1, 1, 6'b0, 32'h20);
      mem_valid_i = 1; mem_exc_flags_i = 5'b11100;
      step("prio_trap", 32'hd, 32'h840, 0, 1, 0, 6'b0, 32'h20);
      mem_valid_i = 0;
      step("prio_fl3", 0, 0, 0, 1, 1, 6'b0, 32'h20);
      mem_valid_i = 1; mem_exc_flags_i = 5'b11000;
      step("prio_ov", 32'hc, 32'h840, 0, 1, 0, 6'b0, 32'h20);
      mem_valid_i = 0;
      step("prio_fl4", 0, 0, 0, 1, 1, 6'b0, 32'h20);
      mem_valid_i = 1; mem_exc_flags_i = 5'b10000; cp0_epc_i = 32'h300;
      step("prio_eret", 32'he, 32'h840, 0, 1, 0, 6'b0, 32'h300);
      clr();
      step("prio_fl5", 0, 0, 0, 1, 1, 6'b0, 32'h300);

      // Second syscall during FLUSH is ignored
      mem_valid_i = 1; mem_exc_flags_i = 5'b00001; mem_pc_i = 32'h900;
      step("sys2_dec", 32'h8, 32'h900, 0, 1, 0, 6'b0, 32'h20);
      mem_pc_i = 32'h904;
      step("sys2_ign", 0, 0, 0, 1, 1, 6'b0, 32'h20);
      clr();
      step("sys2_end", 0, 0, 0, 0, 0, 6'b0, 32'h20);

      // Reset in the middle of a flush aborts it
      mem_valid_i = 1; mem_exc_flags_i = 5'b00001; mem_pc_i = 32'ha00;
      step("rst_dec", 32'h8, 32'ha00, 0, 1, 0, 6'b0, 32'h20);
      clr();
      rst = 1;
      push_rec("rst_mid", 1'b0, 0, 0, 0, 0, 0, 6'b0, 0);
      rst = 0;
      step("rst_after", 0, 0, 0, 0, 0, 6'b0, 0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
